// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_rx_pkg;

    localparam int BAUD           = 434;
    localparam int HALF_BAUD      = 217;
    localparam int W_WORD_LENGHT  = 8;
    localparam int W_FRAME_LENGHT = 10;

    typedef logic [W_WORD_LENGHT-1:0]  word_lenght_t;
    typedef logic [$clog2(BAUD)-1:0]   baud_cnt_t;
    typedef logic [2:0]                bit_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sipo.sv
// Shift-right deserialiser: each new bit enters the MSB, so LSB-first
// serial order lands in natural bit positions after eight shifts.
module uart_rx_sipo
    import uart_rx_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic                     bit_in,
    output logic [W_WORD_LENGHT-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            data <= '0;
        else if (shift_en)
            data <= {bit_in, data[W_WORD_LENGHT-1:1]};
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronise, find the start edge, sample mid-bit,
// and hand bytes out via a valid pulse plus sticky flag/overrun.
module uart_rx #(
    parameter int BAUD      = uart_rx_pkg::BAUD,
    parameter int HALF_BAUD = uart_rx_pkg::HALF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_flag_o,
    input  logic       rx_flag_clr_i,
    output logic       rx_overrun_o,
    output logic       rx_frame_err_o,
    output logic       rx_busy_o
);

    import uart_rx_pkg::*;

    localparam int CNT_W = $clog2(BAUD);
    typedef logic [CNT_W-1:0] cnt_t;

    logic          sync_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          start_edge;

    rx_state_t     state;
    rx_state_t     state_next;
    cnt_t          cnt;
    bit_idx_t      bit_idx;
    logic          half_hit;
    logic          baud_hit;

    logic          shift_en;
    logic          stop_sample;
    word_lenght_t  sipo_data;

    // Synchroniser and edge detect idle high so a quiet line never looks like a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
        end else begin
            sync_meta <= rx_serial_i;
            rx_sync   <= sync_meta;
            rx_prev   <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign half_hit   = (cnt == cnt_t'(HALF_BAUD - 1));
    assign baud_hit   = (cnt == cnt_t'(BAUD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_edge)                       state_next = START;
            START: if (half_hit)                         state_next = rx_sync ? IDLE : DATA;
            DATA:  if (baud_hit && bit_idx == 3'd7)      state_next = STOP;
            STOP:  if (baud_hit)                         state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy_o   = (state != IDLE);
        shift_en    = (state == DATA) && baud_hit;
        stop_sample = (state == STOP) && baud_hit;
    end

    // Counter restarts on every state change so each phase measures from its own entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (state_next != state || state == IDLE || baud_hit)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bit_idx <= '0;
        else if (state != DATA)
            bit_idx <= '0;
        else if (baud_hit)
            bit_idx <= bit_idx + 1'b1;
    end

    uart_rx_sipo u_sipo (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .bit_in   (rx_sync),
        .data     (sipo_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_o      <= '0;
            rx_valid_o     <= 1'b0;
            rx_frame_err_o <= 1'b0;
        end else begin
            rx_valid_o     <= stop_sample &  rx_sync;
            rx_frame_err_o <= stop_sample & ~rx_sync;
            if (stop_sample && rx_sync)
                rx_data_o <= sipo_data;
        end
    end

    // A byte arriving in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_flag_o    <= 1'b0;
            rx_overrun_o <= 1'b0;
        end else begin
            if (rx_valid_o)
                rx_flag_o <= 1'b1;
            else if (rx_flag_clr_i)
                rx_flag_o <= 1'b0;

            if (rx_valid_o) begin
                if (rx_flag_o && !rx_flag_clr_i)
                    rx_overrun_o <= 1'b1;
            end else if (rx_flag_clr_i) begin
                rx_overrun_o <= 1'b0;
            end
        end
    end

endmodule
